// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store FSM over a word memory port; LSU_MISALIGN_TRAP_EN enables misalignment traps
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  misalign,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    output logic                  mem_memwrite,
    output logic                  mem_memread,
    input  logic [DATA_WIDTH-1:0] mem_readdata
);
    typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;
    state_t state, state_n;
    logic l_we, l_sign, trap, accept, done_n;
    logic [1:0] l_size;
    logic [4:0] sh;
    logic [7:0] b;
    logic [15:0] h;
    logic [ADDR_WIDTH-1:0] l_addr;
    logic [DATA_WIDTH-1:0] l_wdata, wbuf, load_val, merged, mask;
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = size[1] ? (addr[1:0] != 2'b00) : (size[0] & addr[0]);
    always_ff @(posedge clk) begin
        if (reset) misalign <= 1'b0;
        else misalign <= (state == IDLE) & req & trap;
    end
`else
    assign trap = 1'b0;
    assign misalign = 1'b0;
`endif
    assign accept = (state == IDLE) & req & ~trap;
    assign busy = state != IDLE;
    assign mem_memread = state == RD;
    assign mem_memwrite = state == WR;
    assign mem_address = {l_addr[ADDR_WIDTH-1:2], 2'b00};
    assign mem_writedata = l_size[1] ? l_wdata : wbuf;
    always_comb begin
        sh = l_size[1] ? 5'd0 : (l_size[0] ? {l_addr[1], 4'b0000} : {l_addr[1:0], 3'b000});
        b = 8'(mem_readdata >> sh);
        h = 16'(mem_readdata >> sh);
        load_val = l_size[1] ? mem_readdata
                 : l_size[0] ? {{16{l_sign & h[15]}}, h}
                 : {{24{l_sign & b[7]}}, b};
        mask = (l_size[0] ? DATA_WIDTH'(16'hFFFF) : DATA_WIDTH'(8'hFF)) << sh;
        merged = (mem_readdata & ~mask) | ((l_wdata << sh) & mask);
        state_n = (state == IDLE) ? (accept ? ((we && size[1]) ? WR : RD) : IDLE)
                : (state == RD) ? CAP
                : (state == CAP) ? (l_we ? WR : IDLE)
                : IDLE;
        done_n = ((state == CAP) & ~l_we) | (state == WR) | ((state == IDLE) & req & trap);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            done <= 1'b0;
            rdata <= '0;
            wbuf <= '0;
            l_we <= 1'b0;
            l_sign <= 1'b0;
            l_size <= 2'b00;
            l_addr <= '0;
            l_wdata <= '0;
        end else begin
            state <= state_n;
            done <= done_n;
            if (accept) begin
                l_we <= we;
                l_sign <= sign_ext;
                l_size <= size;
                l_addr <= addr;
                l_wdata <= wdata;
            end
            if (state == CAP && l_we) wbuf <= merged;
            if (state == CAP && !l_we) rdata <= load_val;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven scoreboard bench against a registered-read word memory model
module tb_load_store_unit;
    logic clk = 1'b0, reset = 1'b1, req = 1'b0, we = 1'b0, sign_ext = 1'b0;
    logic [1:0] size = 2'b00;
    logic [31:0] addr = '0, wdata = '0, rdata, mem_address, mem_writedata, mem_readdata, rd_q;
    logic busy, done, misalign, mem_memwrite, mem_memread, prev_done = 1'b0;
    logic [31:0] mem [0:63];
    int cyc = 0, total = 0, bad = 0, rd_tot = 0, wr_tot = 0, busy_tot = 0;

    typedef struct {
        string name;
        logic [31:0] rdata;
        logic mis;
        int dcyc, rd0, wr0, bz0, nrd, nwr, nbusy;
    } exp_t;
    typedef struct {
        string name;
        logic we;
        logic [1:0] size;
        logic sx;
        logic [31:0] addr, wdata, exp;
        logic mis;
        int lat, nrd, nwr, midx;
        logic [31:0] mval;
    } vec_t;
    exp_t sb[$];
    vec_t vt[17];

    load_store_unit dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .misalign(misalign),
        .mem_address(mem_address), .mem_writedata(mem_writedata), .mem_memwrite(mem_memwrite),
        .mem_memread(mem_memread), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (mem_memread) rd_q <= mem[mem_address[7:2]];
        if (mem_memwrite) mem[mem_address[7:2]] <= mem_writedata;
    end
    assign mem_readdata = rd_q;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        rd_tot += int'(mem_memread);
        wr_tot += int'(mem_memwrite);
        busy_tot += int'(busy);
        if (mem_memread) chk("strobe_excl", {31'b0, mem_memwrite}, 0);
        if (done) begin
            chk("done_single", {31'b0, prev_done}, 0);
            if (sb.size() == 0) chk("spurious_done", {31'b0, done}, 0);
            else begin
                e = sb.pop_front();
                chk({e.name, "_cycle"}, 32'(cyc), 32'(e.dcyc));
                chk({e.name, "_rdata"}, rdata, e.rdata);
                chk({e.name, "_misalign"}, {31'b0, misalign}, {31'b0, e.mis});
                chk({e.name, "_reads"}, 32'(rd_tot - e.rd0), 32'(e.nrd));
                chk({e.name, "_writes"}, 32'(wr_tot - e.wr0), 32'(e.nwr));
                chk({e.name, "_busy"}, 32'(busy_tot - e.bz0), 32'(e.nbusy));
            end
        end
        prev_done = done;
    end

    task automatic push(input string n, input logic [31:0] r, input logic m, input int dc, input int nr, input int nw, input int nb);
        exp_t e;
        e.name = n; e.rdata = r; e.mis = m; e.dcyc = dc;
        e.rd0 = rd_tot; e.wr0 = wr_tot; e.bz0 = busy_tot;
        e.nrd = nr; e.nwr = nw; e.nbusy = nb;
        sb.push_back(e);
    endtask

    task automatic wait_sb();
        for (int i = 0; i < 12 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            chk("timeout", 32'(sb.size()), 0);
            sb.delete();
        end
    endtask

    function automatic vec_t mk(input string n, input logic w, input logic [1:0] s, input logic x,
                                input logic [31:0] a, input logic [31:0] d, input logic [31:0] e,
                                input logic m, input int l, input int nr, input int nw,
                                input int mi, input logic [31:0] mv);
        vec_t v;
        v.name = n; v.we = w; v.size = s; v.sx = x; v.addr = a; v.wdata = d; v.exp = e;
        v.mis = m; v.lat = l; v.nrd = nr; v.nwr = nw; v.midx = mi; v.mval = mv;
        return v;
    endfunction

    task automatic run(input vec_t v);
        push(v.name, v.exp, v.mis, cyc + 1 + v.lat, v.nrd, v.nwr, v.lat);
        req = 1; we = v.we; size = v.size; sign_ext = v.sx; addr = v.addr; wdata = v.wdata;
        @(posedge clk);
        #1;
        req = 0; addr = $urandom; wdata = $urandom; sign_ext = ~v.sx;
        wait_sb();
        if (v.midx >= 0) chk({v.name, "_mem"}, mem[v.midx], v.mval);
    endtask

    initial begin
        logic [31:0] snap;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i);
`ifdef LSU_MISALIGN_TRAP_EN
        vt[0] = mk("ldw_mis", 0, 2'b10, 0, 32'h16, 0, 32'h0, 1, 0, 0, 0, -1, 0);
`else
        vt[0] = mk("ldw_mis", 0, 2'b10, 0, 32'h16, 0, 32'h5, 0, 2, 1, 0, -1, 0);
`endif
        vt[1]  = mk("ldw14",  0, 2'b10, 0, 32'h14, 0,            32'h00000005, 0, 2, 1, 0, -1, 0);
        vt[2]  = mk("stb15",  1, 2'b00, 0, 32'h15, 32'h000000AB, 32'h00000005, 0, 3, 1, 1, 5, 32'h0000AB05);
        vt[3]  = mk("ldw14b", 0, 2'b10, 0, 32'h14, 0,            32'h0000AB05, 0, 2, 1, 0, -1, 0);
        vt[4]  = mk("stw14",  1, 2'b10, 0, 32'h14, 32'h80FF7F01, 32'h0000AB05, 0, 1, 0, 1, 5, 32'h80FF7F01);
        vt[5]  = mk("lb17",   0, 2'b00, 1, 32'h17, 0,            32'hFFFFFF80, 0, 2, 1, 0, -1, 0);
        vt[6]  = mk("lbu17",  0, 2'b00, 0, 32'h17, 0,            32'h00000080, 0, 2, 1, 0, -1, 0);
        vt[7]  = mk("lh16",   0, 2'b01, 1, 32'h16, 0,            32'hFFFF80FF, 0, 2, 1, 0, -1, 0);
        vt[8]  = mk("lhu14",  0, 2'b01, 0, 32'h14, 0,            32'h00007F01, 0, 2, 1, 0, -1, 0);
        vt[9]  = mk("lb14",   0, 2'b00, 1, 32'h14, 0,            32'h00000001, 0, 2, 1, 0, -1, 0);
        vt[10] = mk("sth1e",  1, 2'b01, 0, 32'h1E, 32'h5678ABCD, 32'h00000001, 0, 3, 1, 1, 7, 32'hABCD0007);
        vt[11] = mk("ld11_1c", 0, 2'b11, 0, 32'h1C, 0,           32'hABCD0007, 0, 2, 1, 0, -1, 0);
        vt[12] = mk("lh1e",   0, 2'b01, 1, 32'h1E, 0,            32'hFFFFABCD, 0, 2, 1, 0, -1, 0);
        vt[13] = mk("lbu1f",  0, 2'b00, 0, 32'h1F, 0,            32'h000000AB, 0, 2, 1, 0, -1, 0);
        vt[14] = mk("stb1c",  1, 2'b00, 0, 32'h1C, 32'h0000007F, 32'h000000AB, 0, 3, 1, 1, 7, 32'hABCD007F);
        vt[15] = mk("st11_10", 1, 2'b11, 0, 32'h10, 32'hCAFEF00D, 32'h000000AB, 0, 1, 0, 1, 4, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_TRAP_EN
        vt[16] = mk("sth11",  1, 2'b01, 0, 32'h11, 32'h00001111, 32'h000000AB, 1, 0, 0, 0, 4, 32'hCAFEF00D);
`else
        vt[16] = mk("sth11",  1, 2'b01, 0, 32'h11, 32'h00001111, 32'h000000AB, 0, 3, 1, 1, 4, 32'hCAFE1111);
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_misalign", {31'b0, misalign}, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_wdata", mem_writedata, 0);
        chk("rst_strobes", {30'b0, mem_memread, mem_memwrite}, 0);
        for (int i = 0; i < 17; i++) run(vt[i]);

        push("b2b_first", 32'h80FF7F01, 0, cyc + 3, 1, 0, 2);
        push("b2b_second", 32'h00000006, 0, cyc + 6, 2, 0, 4);
        req = 1; we = 0; size = 2'b10; sign_ext = 0; addr = 32'h14;
        for (int i = 0; i < 8 && !done; i++) begin
            @(posedge clk);
            #1;
        end
        addr = 32'h18;
        @(posedge clk);
        #1;
        req = 0;
        wait_sb();

        push("busy_drop", 32'h80FF7F01, 0, cyc + 3, 1, 0, 2);
        req = 1; addr = 32'h14;
        @(posedge clk);
        #1;
        addr = 32'h18;
        @(posedge clk);
        #1;
        req = 0;
        wait_sb();
        snap = 32'(rd_tot);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_drop_nostrobe", 32'(rd_tot), snap);

        snap = 32'(wr_tot);
        req = 1; we = 1; size = 2'b00; addr = 32'h18; wdata = 32'hEE;
        @(posedge clk);
        #1;
        req = 0;
        @(posedge clk);
        #1;
        chk("rst_cap_busy", {31'b0, busy}, 1);
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        chk("rstmid_busy", {31'b0, busy}, 0);
        chk("rstmid_done", {31'b0, done}, 0);
        chk("rstmid_rdata", rdata, 0);
        chk("rstmid_addr", mem_address, 0);
        chk("rstmid_wdata", mem_writedata, 0);
        chk("rstmid_strobes", {30'b0, mem_memread, mem_memwrite}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid_mem6", mem[6], 32'h6);
        chk("rstmid_nowrite", 32'(wr_tot), snap);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end
endmodule
